core_bus_responder: RTL
=======================

Name: core_bus_responder

Overview:
- Memory-side responder for the core's two bus masters: the instruction prefetch port and the data load/store port.
- Arbitrates the two masters onto one external 16-bit SRAM port with a fixed wait-state count.
- Routes data accesses flagged d_io to a separate I/O handshake port.
- Returns registered read data with a single-cycle ack pulse. Sits between the core and the board memory/peripheral fabric.

Parameters:
WAIT_STATES, 1, extra SRAM cycles before read data is valid (0..15)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
instr_m_addr  in  19  instruction word address [19:1]
instr_m_access  in  1  instruction request, held until ack
instr_m_ack  out  1  one-cycle completion pulse
instr_m_data_in  out  16  instruction read data, valid with ack
data_m_addr  in  19  data word address [19:1]
data_m_data_out  in  16  write data from core
data_m_access  in  1  data request, held until ack
data_m_wr_en  in  1  1=write
data_m_bytesel  in  2  byte lanes
d_io  in  1  data access targets I/O space
data_m_ack  out  1  one-cycle completion pulse
data_m_data_in  out  16  data read data, valid with ack
sram_addr  out  19  SRAM word address
sram_wdata  out  16  SRAM write data
sram_rdata  in  16  SRAM read data
sram_cs  out  1  SRAM select
sram_we  out  1  SRAM write strobe
sram_be  out  2  SRAM byte enables
io_addr  out  16  I/O port address (data_m_addr[15:1], 0)
io_wdata  out  16  I/O write data
io_rdata  in  16  I/O read data
io_access  out  1  I/O request, held until io_ack
io_wr_en  out  1  I/O write
io_bytesel  out  2  I/O byte lanes
io_ack  in  1  I/O completion

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0. An in-flight access is abandoned, including a partial SRAM write.
- States: IDLE, MEM (wait counter), IO, ACK.
- Arbitration in IDLE: data_m_access wins over instr_m_access; instruction is served only when no data request is pending. Winner's address, write data, bytesel, wr_en and port are latched at the accepting edge.
- IDLE -> MEM: accepted instruction request, or data request with d_io=0.
  - In MEM: sram_cs=1; sram_addr/sram_be driven from latches; counter loaded with WAIT_STATES.
  - Instruction accesses use sram_be=2'b11; data accesses use latched bytesel.
  - Writes: sram_we=1 for the whole MEM period.
  - Stay in MEM until the counter reaches 0. On the edge leaving MEM, capture sram_rdata into the read-data register; go to ACK.
  - MEM occupies WAIT_STATES+1 cycles.
- IDLE -> IO: data request with d_io=1.
  - io_access held high; io_addr/io_wdata/io_wr_en/io_bytesel held from latches.
  - On the cycle io_ack=1: capture io_rdata, drop io_access next cycle, go to ACK.
- ACK (1 cycle): pulse the ack of the served port only; the port's data output holds the captured value. Go to IDLE.
  - Writes return 0 on data_m_data_in.
  - Read data outputs hold their last value until the next ack.
- Latency: request accepted at edge E0 → ack high in cycle E0+WAIT_STATES+2. The master deasserts access at the edge where it samples ack, so IDLE never re-serves the same request.
- Boundary conditions:
  - Both requests present in IDLE: data served first; instruction served in the next IDLE cycle if still held.
  - A request arriving during MEM/IO/ACK waits in IDLE.
  - Counter never wraps; WAIT_STATES=0 gives a single MEM cycle.
  - sram_we is never high outside MEM.
  - instr_m_ack and data_m_ack are never high together.

Optional Feature:
- Macro: CORE_BUS_IO_TIMEOUT_EN.
- Defined: the IO state counts cycles with an 8-bit counter. If io_ack is not received within 255 cycles, io_access is dropped, read data is forced to 16'hFFFF, and the FSM goes to ACK.
- Not defined: the IO state waits indefinitely for io_ack.

Decomposition:
- Shared package (with the other bus constants): state enum (IDLE/MEM/IO/ACK), served-port enum (PORT_INSTR/PORT_DATA), timeout-limit constant.
- One natural sub-module: bus_wait_counter (load, decrement, zero flag). It is reused for the optional timeout.

Test Plan:
- WAIT_STATES=1; instr read at 0x00100 with sram_rdata=16'hA55A → instr_m_ack one cycle in cycle 3 after accept, instr_m_data_in=16'hA55A, sram_we never 1.
- Data write addr 0x12345, data 16'hBEEF, bytesel 2'b10 → sram_we=1 and sram_be=2'b10 for 2 cycles, then data_m_ack pulse, data_m_data_in=0.
- Instr and data requests raised in the same cycle → data acked first; instr acked 4 cycles later; acks never overlap.
- d_io=1 read port 0x0060; io_ack raised after 5 cycles with io_rdata=16'h00FA → sram_cs stays 0, data_m_ack next cycle, data_m_data_in=16'h00FA.
- Reset asserted mid-MEM write → all outputs 0 immediately (async); after release, a new instr read completes normally.
- CORE_BUS_IO_TIMEOUT_EN defined, io_ack held 0 → data_m_ack after 255 IO cycles, data_m_data_in=16'hFFFF.

Source files
------------

// File: rtl/core_bus_responder_pkg.sv
// rtl/core_bus_responder_pkg.sv - shared state, port and limit definitions for the core bus responder
package core_bus_responder_pkg;

    typedef logic [1:0] bus_state_t;

    localparam bus_state_t ST_IDLE = 2'd0;
    localparam bus_state_t ST_MEM  = 2'd1;
    localparam bus_state_t ST_IO   = 2'd2;
    localparam bus_state_t ST_ACK  = 2'd3;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } bus_port_e;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CNT_W-1:0]  IO_TIMEOUT_LIMIT = 8'd255;
    localparam logic [DATA_W-1:0] IO_TIMEOUT_DATA  = 16'hFFFF;
    localparam logic [1:0]        BE_FULL          = 2'b11;

    // Instruction fetches always read the full word.
    function automatic logic [1:0] sram_be_for(input bus_port_e port, input logic [1:0] be);
        return (port == PORT_INSTR) ? BE_FULL : be;
    endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// rtl/bus_wait_counter.sv - loadable down counter with zero flag for SRAM wait states and I/O timeout
module bus_wait_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/core_bus_responder.sv
// rtl/core_bus_responder.sv - arbitrates instruction/data masters onto SRAM and I/O ports
// Optional I/O timeout enabled by defining CORE_BUS_IO_TIMEOUT_EN.
module core_bus_responder
    import core_bus_responder_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] instr_m_addr,
    input  logic        instr_m_access,
    output logic        instr_m_ack,
    output logic [15:0] instr_m_data_in,
    input  logic [18:0] data_m_addr,
    input  logic [15:0] data_m_data_out,
    input  logic        data_m_access,
    input  logic        data_m_wr_en,
    input  logic [1:0]  data_m_bytesel,
    input  logic        d_io,
    output logic        data_m_ack,
    output logic [15:0] data_m_data_in,
    output logic [18:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_cs,
    output logic        sram_we,
    output logic [1:0]  sram_be,
    output logic [15:0] io_addr,
    output logic [15:0] io_wdata,
    input  logic [15:0] io_rdata,
    output logic        io_access,
    output logic        io_wr_en,
    output logic [1:0]  io_bytesel,
    input  logic        io_ack
);

    bus_state_t        state_q, state_d;
    bus_port_e         port_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        be_q;
    logic              wr_q;
    logic [DATA_W-1:0] instr_rdata_q;
    logic [DATA_W-1:0] data_rdata_q;

    logic              accept_data;
    logic              accept_instr;
    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              capture;
    logic [DATA_W-1:0] capture_val;

    bus_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        accept_data  = 1'b0;
        accept_instr = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        capture      = 1'b0;
        capture_val  = '0;
        case (state_q)
            ST_IDLE: begin
                // Data master has priority; instruction only goes when data is quiet.
                if (data_m_access) begin
                    accept_data = 1'b1;
                    cnt_load    = 1'b1;
                    if (d_io) begin
                        state_d      = ST_IO;
                        cnt_load_val = IO_TIMEOUT_LIMIT - 1'b1;
                    end else begin
                        state_d      = ST_MEM;
                        cnt_load_val = CNT_W'(WAIT_STATES);
                    end
                end else if (instr_m_access) begin
                    accept_instr = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(WAIT_STATES);
                    state_d      = ST_MEM;
                end
            end
            ST_MEM: begin
                if (cnt_zero) begin
                    state_d     = ST_ACK;
                    capture     = 1'b1;
                    capture_val = wr_q ? '0 : sram_rdata;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_IO: begin
                if (io_ack) begin
                    state_d     = ST_ACK;
                    capture     = 1'b1;
                    capture_val = wr_q ? '0 : io_rdata;
                end
`ifdef CORE_BUS_IO_TIMEOUT_EN
                else if (cnt_zero) begin
                    state_d     = ST_ACK;
                    capture     = 1'b1;
                    capture_val = wr_q ? '0 : IO_TIMEOUT_DATA;
                end else begin
                    cnt_dec = 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            port_q        <= PORT_INSTR;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            wr_q          <= 1'b0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept_data) begin
                port_q  <= PORT_DATA;
                addr_q  <= data_m_addr;
                wdata_q <= data_m_data_out;
                be_q    <= data_m_bytesel;
                wr_q    <= data_m_wr_en;
            end else if (accept_instr) begin
                port_q  <= PORT_INSTR;
                addr_q  <= instr_m_addr;
                wdata_q <= '0;
                be_q    <= BE_FULL;
                wr_q    <= 1'b0;
            end
            if (capture) begin
                if (port_q == PORT_DATA) begin
                    data_rdata_q <= capture_val;
                end else begin
                    instr_rdata_q <= capture_val;
                end
            end
        end
    end

    logic in_mem, in_io, in_ack;
    assign in_mem = (state_q == ST_MEM);
    assign in_io  = (state_q == ST_IO);
    assign in_ack = (state_q == ST_ACK);

    assign sram_cs    = in_mem;
    assign sram_we    = in_mem & wr_q;
    assign sram_addr  = in_mem ? addr_q : '0;
    assign sram_be    = in_mem ? sram_be_for(port_q, be_q) : 2'b00;
    assign sram_wdata = (in_mem & wr_q) ? wdata_q : '0;

    assign io_access  = in_io;
    assign io_wr_en   = in_io & wr_q;
    assign io_addr    = in_io ? {addr_q[14:0], 1'b0} : '0;
    assign io_bytesel = in_io ? be_q : 2'b00;
    assign io_wdata   = (in_io & wr_q) ? wdata_q : '0;

    assign instr_m_ack     = in_ack & (port_q == PORT_INSTR);
    assign data_m_ack      = in_ack & (port_q == PORT_DATA);
    assign instr_m_data_in = instr_rdata_q;
    assign data_m_data_in  = data_rdata_q;

endmodule
